// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jam_pkg
// Brief    : FSM state encoding and width helpers for the jam assignment solver
// Revision : 1.0 - initial release
// ============================================================================
package jam_pkg;

    typedef enum logic [1:0] {
        EVAL = 2'd0,
        UPD  = 2'd1,
        DONE = 2'd2
    } jam_state_e;

    // Index width; a 1-bit index is kept even when log2 would give zero
    function automatic int calc_iw(input int n);
        int c;
        c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

    // Accumulator width large enough for N maximum costs
    function automatic int calc_sw(input int n, input int cw);
        return cw + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jam_nextperm.sv
`default_nettype none
// ============================================================================
// Module   : jam_nextperm
// Brief    : combinational lexicographic successor (pivot / swap / reverse)
// Revision : 1.0 - initial release
// ============================================================================
module jam_nextperm
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N*IW-1:0] i_perm,
    output logic [N*IW-1:0] o_next_perm,
    output logic            o_is_last
);

    logic [IW-1:0] w_p [N];
    logic [IW-1:0] w_s [N];
    logic [IW-1:0] w_piv;
    logic [IW-1:0] w_swp;
    logic          w_found;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_p[g] = i_perm[g*IW +: IW];
    end

    // Pivot: rightmost position whose element is smaller than its right neighbour
    always_comb begin
        w_found = 1'b0;
        w_piv   = '0;
        for (int k = 0; k < N-1; k++) begin
            if (w_p[k] < w_p[k+1]) begin
                w_found = 1'b1;
                w_piv   = IW'(k);
            end
        end
    end

    always_comb begin
        w_swp = w_piv;
        for (int k = 0; k < N; k++) begin
            if (k > int'(w_piv) && w_p[k] > w_p[w_piv])
                w_swp = IW'(k);
        end
    end

    // Suffix after the pivot stays descending after the swap; reversing it sorts it
    always_comb begin
        for (int k = 0; k < N; k++)
            w_s[k] = w_p[k];
        w_s[w_piv] = w_p[w_swp];
        w_s[w_swp] = w_p[w_piv];
        for (int k = 0; k < N; k++) begin
            o_next_perm[k*IW +: IW] = w_s[k];
            if (w_found && k > int'(w_piv))
                o_next_perm[k*IW +: IW] = w_s[IW'(N + int'(w_piv) - k)];
        end
    end

    assign o_is_last = ~w_found;

endmodule
`default_nettype wire

// File: rtl/jam_param.sv
`default_nettype none
// ============================================================================
// Module   : jam_param
// Brief    : exhaustive N x N assignment solver; min cost, tie count, best perm
// Revision : 1.0 - initial release
// ============================================================================
module jam_param
    import jam_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int CW  = 7,
    parameter  int MCW = 16,
    localparam int IW  = calc_iw(N),
    localparam int SW  = calc_sw(N, CW)
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [IW-1:0]     W,
    output logic [IW-1:0]     J,
    input  logic [CW-1:0]     Cost,
    output logic [SW-1:0]     MinCost,
    output logic [MCW-1:0]    MatchCount,
    output logic [N*IW-1:0]   BestPerm,
    output logic              Valid
);

    localparam logic [1:0]    c_ST_EVAL = EVAL;
    localparam logic [1:0]    c_ST_UPD  = UPD;
    localparam logic [1:0]    c_ST_DONE = DONE;
    localparam logic [IW-1:0] c_W_LAST  = IW'(N-1);

    logic [1:0]      r_state;
    logic [IW-1:0]   r_w;
    logic [N*IW-1:0] r_perm;
    logic [SW-1:0]   r_acc;
    logic [SW-1:0]   r_min;
    logic [MCW-1:0]  r_count;
    logic [N*IW-1:0] r_best;
    logic            r_valid;

    logic [N*IW-1:0] w_next_perm;
    logic            w_is_last;
    logic [SW-1:0]   w_cost_ext;
    logic [IW-1:0]   w_perm_arr [N];

    jam_nextperm #(
        .N  (N),
        .IW (IW)
    ) u_nextperm (
        .i_perm      (r_perm),
        .o_next_perm (w_next_perm),
        .o_is_last   (w_is_last)
    );

    for (genvar g = 0; g < N; g++) begin : g_perm_unpack
        assign w_perm_arr[g] = r_perm[g*IW +: IW];
    end

    assign W          = (r_state == c_ST_EVAL) ? r_w : '0;
    assign J          = w_perm_arr[W];
    assign w_cost_ext = SW'(Cost);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_EVAL;
            r_w     <= '0;
            for (int k = 0; k < N; k++)
                r_perm[k*IW +: IW] <= IW'(k);
            r_acc   <= '0;
            r_min   <= '1;
            r_count <= '0;
            r_best  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_EVAL: begin
                    r_acc <= (r_w == '0) ? w_cost_ext : r_acc + w_cost_ext;
                    if (r_w == c_W_LAST) begin
                        r_w     <= '0;
                        r_state <= c_ST_UPD;
                    end else begin
                        r_w <= r_w + 1'b1;
                    end
                end
                c_ST_UPD: begin
                    // Strict less-than keeps the lexicographically first minimum on ties
                    if (r_acc < r_min) begin
                        r_min   <= r_acc;
                        r_count <= {{(MCW-1){1'b0}}, 1'b1};
                        r_best  <= r_perm;
                    end else if (r_acc == r_min && r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (w_is_last) begin
                        r_state <= c_ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_perm  <= w_next_perm;
                        r_state <= c_ST_EVAL;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_EVAL;
                end
            endcase
        end
    end

    assign MinCost    = r_min;
    assign MatchCount = r_count;
    assign BestPerm   = r_best;
    assign Valid      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_jam_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_param
// Brief    : scoreboard bench for jam_param with N=3 and N=4 instances
// Revision : 1.0 - initial release
// ============================================================================
module tb_jam_param;

    typedef struct {
        int         mn;
        int         cnt;
        logic [7:0] best;
        int         lat;
    } exp_t;

    logic clk;
    logic rst;
    logic sel;
    int   total;
    int   bad;
    int   done_cnt;
    int   edge_cnt;
    exp_t q[$];

    logic [6:0] tbl [4][4];

    logic [1:0]  w3, j3;
    logic [6:0]  cost3;
    logic [8:0]  min3;
    logic [15:0] cnt3;
    logic [5:0]  best3;
    logic        v3;

    logic [1:0]  w4, j4;
    logic [4:0]  cost4;
    logic [6:0]  min4;
    logic [2:0]  cnt4;
    logic [7:0]  best4;
    logic        v4;

    logic        m_valid;
    int          m_min;
    int          m_cnt;
    logic [7:0]  m_best;
    logic [1:0]  m_w;
    logic [1:0]  m_j;

    jam_param #(.N(3), .CW(7), .MCW(16)) u_dut3 (
        .CLK(clk), .RST(rst | sel), .W(w3), .J(j3), .Cost(cost3),
        .MinCost(min3), .MatchCount(cnt3), .BestPerm(best3), .Valid(v3)
    );

    jam_param #(.N(4), .CW(5), .MCW(3)) u_dut4 (
        .CLK(clk), .RST(rst | ~sel), .W(w4), .J(j4), .Cost(cost4),
        .MinCost(min4), .MatchCount(cnt4), .BestPerm(best4), .Valid(v4)
    );

    assign cost3   = tbl[w3][j3];
    assign cost4   = tbl[w4][j4][4:0];
    assign m_valid = sel ? v4 : v3;
    assign m_min   = sel ? 32'(min4) : 32'(min3);
    assign m_cnt   = sel ? 32'(cnt4) : 32'(cnt3);
    assign m_best  = sel ? best4 : {2'b00, best3};
    assign m_w     = sel ? w4 : w3;
    assign m_j     = sel ? j4 : j3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Reference: walk every n-digit base-n tuple in ascending order and keep the permutations
    function automatic void model(input int n, input int maxc, output exp_t e);
        int tup[4];
        int c;
        int sum;
        bit ok;
        int f;
        e.mn   = 1 << 30;
        e.cnt  = 0;
        e.best = '0;
        for (int code = 0; code < n**n; code++) begin
            c = code;
            for (int k = n-1; k >= 0; k--) begin
                tup[k] = c % n;
                c      = c / n;
            end
            ok = 1'b1;
            for (int a = 0; a < n; a++)
                for (int b = a+1; b < n; b++)
                    if (tup[a] == tup[b]) ok = 1'b0;
            if (!ok) continue;
            sum = 0;
            for (int k = 0; k < n; k++) sum += int'(tbl[k][tup[k]]);
            if (sum < e.mn) begin
                e.mn   = sum;
                e.cnt  = 1;
                e.best = '0;
                for (int k = 0; k < n; k++) e.best[k*2 +: 2] = tup[k][1:0];
            end else if (sum == e.mn && e.cnt < maxc) begin
                e.cnt++;
            end
        end
        f = 1;
        for (int k = 2; k <= n; k++) f *= k;
        e.lat = f * (n + 1);
    endfunction

    task automatic run_case(input logic s, input exp_t e, input bit pulse);
        int start;
        int waited;
        @(negedge clk);
        sel = s;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_count", m_cnt, 0);
        chk("rst_min", m_min, s ? 127 : 511);
        chk("rst_best", int'(m_best), 0);
        q.push_back(e);
        start = done_cnt;
        rst   = 1'b0;
        if (pulse) begin
            repeat (9) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        waited = 0;
        while (done_cnt == start && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (done_cnt == start) begin
            total++;
            bad++;
            $display("FAIL timeout: Valid not seen after %0d cycles", waited);
            q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   seen;
        int   n;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            n = sel ? 4 : 3;
            if (rst) begin
                seen = 1'b0;
            end else if (!m_valid) begin
                total++;
                if (int'(m_w) >= n || int'(m_j) >= n) begin
                    bad++;
                    $display("FAIL index_range: W=%0d J=%0d, required both below %0d", m_w, m_j, n);
                end
            end else if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got Valid=1, required no pending result");
                end else begin
                    e = q.pop_front();
                    chk("latency", edge_cnt, e.lat);
                    chk("min_cost", m_min, e.mn);
                    chk("match_count", m_cnt, e.cnt);
                    chk("best_perm", int'(m_best), int'(e.best));
                    repeat (3) @(negedge clk);
                    chk("hold_valid", int'(m_valid), 1);
                    chk("hold_min", m_min, e.mn);
                    chk("hold_best", int'(m_best), int'(e.best));
                    done_cnt++;
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        rst      = 1'b1;
        sel      = 1'b0;

        for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) tbl[w][j] = 7'd0;
        e = '{mn: 0, cnt: 6, best: 8'h24, lat: 24};
        run_case(1'b0, e, 1'b0);
        run_case(1'b0, e, 1'b1);

        for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) tbl[w][j] = (w == j) ? 7'd1 : 7'd10;
        e = '{mn: 3, cnt: 1, best: 8'h24, lat: 24};
        run_case(1'b0, e, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) tbl[w][j] = 7'($urandom_range(0, 127));
            model(3, 65535, e);
            run_case(1'b0, e, 1'b0);
        end

        for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) tbl[w][j] = (j == 3 - w) ? 7'd0 : 7'd5;
        e = '{mn: 0, cnt: 1, best: 8'h1B, lat: 120};
        run_case(1'b1, e, 1'b0);

        for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) tbl[w][j] = 7'd0;
        e = '{mn: 0, cnt: 7, best: 8'hE4, lat: 120};
        run_case(1'b1, e, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) tbl[w][j] = 7'($urandom_range(0, 3));
            model(4, 7, e);
            run_case(1'b1, e, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
